// File: rtl/frame_buffer_port_if.sv
// Bus bundle for frame_buffer_port: pixel write port, scan-out request and
// response, and the ready / frame-done status lines.
interface frame_buffer_port_if;
  logic [7:0]  write_x;
  logic [7:0]  write_y;
  logic [2:0]  write_r;
  logic [2:0]  write_g;
  logic [2:0]  write_b;
  logic        write_en;
  logic [10:0] iCurrent_X;
  logic [10:0] iCurrent_Y;
  logic        iRequest;
  logic [7:0]  oR;
  logic [7:0]  oG;
  logic [7:0]  oB;
  logic        oValid;
  logic        oReady;
  logic        oFrameDone;

  modport master (
    output write_x, write_y, write_r, write_g, write_b, write_en,
    output iCurrent_X, iCurrent_Y, iRequest,
    input  oR, oG, oB, oValid, oReady, oFrameDone
  );

  modport slave (
    input  write_x, write_y, write_r, write_g, write_b, write_en,
    input  iCurrent_X, iCurrent_Y, iRequest,
    output oR, oG, oB, oValid, oReady, oFrameDone
  );
endinterface

// File: rtl/frame_buffer_port.sv
// 256x256x9 image buffer swept to zero after reset, with a two-edge write
// pipeline and a two-cycle windowed scan-out read path.
//   state    | meaning
//   ST_CLEAR | zeroing one word per cycle from address 0, writes dropped
//   ST_RUN   | accepting pixel writes, oReady high
module frame_buffer_port #(
  parameter int          IMG_X0 = 272,
  parameter int          IMG_Y0 = 172,
  parameter logic [23:0] BG_RGB = 24'h000000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  frame_buffer_port_if.slave fb
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  localparam logic [11:0] X_LO = 12'(IMG_X0);
  localparam logic [11:0] X_HI = 12'(IMG_X0 + 256);
  localparam logic [11:0] Y_LO = 12'(IMG_Y0);
  localparam logic [11:0] Y_HI = 12'(IMG_Y0 + 256);

  state_e      state_q, state_d;
  logic [15:0] clr_addr_q, clr_addr_d;
  logic        clr_we;

  logic        wr_vld_q, wr_vld_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [8:0]  wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;

  logic [11:0] cur_x, cur_y;
  logic        rd_req_q, rd_req_d;
  logic        rd_win_q, rd_win_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        out_vld_q, out_win_q;
  logic [8:0]  rd_data_q;

  logic [8:0]  mem_q [0:65535];
  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [8:0]  mem_wdata;

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      wr_vld_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_win_q     <= 1'b0;
      rd_addr_q    <= '0;
      out_vld_q    <= 1'b0;
      out_win_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wr_vld_q     <= wr_vld_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      rd_req_q     <= rd_req_d;
      rd_win_q     <= rd_win_d;
      rd_addr_q    <= rd_addr_d;
      out_vld_q    <= rd_req_q;
      out_win_q    <= rd_win_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we     = 1'b1;
        clr_addr_d = clr_addr_q + 16'd1;
        if (clr_addr_q == 16'hFFFF) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Writes arriving while still clearing are dropped at the first stage.
  always_comb begin
    wr_vld_d     = (state_q == ST_RUN) && fb.write_en;
    wr_addr_d    = {fb.write_y, fb.write_x};
    wr_data_d    = {fb.write_r, fb.write_g, fb.write_b};
    frame_done_d = wr_vld_q && (wr_addr_q == 16'hFFFF);
    mem_we       = clr_we || wr_vld_q;
    mem_waddr    = clr_we ? clr_addr_q : wr_addr_q;
    mem_wdata    = clr_we ? 9'h000 : wr_data_q;
  end

  // Compare in 12 bits so coordinates below the origin never wrap into the window.
  always_comb begin
    cur_x     = {1'b0, fb.iCurrent_X};
    cur_y     = {1'b0, fb.iCurrent_Y};
    rd_req_d  = fb.iRequest;
    rd_win_d  = (cur_x >= X_LO) && (cur_x < X_HI) && (cur_y >= Y_LO) && (cur_y < Y_HI);
    rd_addr_d = {8'(cur_y - Y_LO), 8'(cur_x - X_LO)};
  end

  // Read sees the pre-write word when it shares an edge with a commit.
  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem_q[rd_addr_q];
  end

  always_comb begin
    {fb.oR, fb.oG, fb.oB} = 24'h000000;
    if (out_vld_q) begin
      if (out_win_q) begin
        {fb.oR, fb.oG, fb.oB} = {expand3(rd_data_q[8:6]), expand3(rd_data_q[5:3]),
                                 expand3(rd_data_q[2:0])};
      end else begin
        {fb.oR, fb.oG, fb.oB} = BG_RGB;
      end
    end
  end

  assign fb.oValid     = out_vld_q;
  assign fb.oReady     = (state_q == ST_RUN);
  assign fb.oFrameDone = frame_done_q;

endmodule

// File: doc/frame_buffer_port.md
FRAME_BUFFER_PORT -- requirements
Module: frame_buffer_port

Interface
REQ-001 Parameter IMG_X0, default 272, SHALL set the screen column of image pixel x=0.
REQ-002 Parameter IMG_Y0, default 172, SHALL set the screen row of image pixel y=0.
REQ-003 Parameter BG_RGB, default 24'h000000, SHALL set the {R,G,B} colour output outside the image window.
REQ-004 iCLK  in  1  SHALL be the single clock (40 MHz pixel clock).
REQ-005 iRST_N  in  1  SHALL be the reset; asynchronous assert, active-low.
REQ-006 write_x  in  8  SHALL carry the image column of the write pixel.
REQ-007 write_y  in  8  SHALL carry the image row of the write pixel.
REQ-008 write_r, write_g, write_b  in  3 each  SHALL carry the write pixel colour.
REQ-009 write_en  in  1  SHALL qualify the write pixel; it is sampled every clock.
REQ-010 iCurrent_X, iCurrent_Y  in  11 each  SHALL carry the scan-out screen coordinate.
REQ-011 iRequest  in  1  SHALL mark iCurrent_X/Y as an active-area pixel request.
REQ-012 oR, oG, oB  out  8 each  SHALL carry the scan-out colour.
REQ-013 oValid  out  1  SHALL mark oR/oG/oB as the response to a request.
REQ-014 oReady  out  1  SHALL be high when the buffer accepts writes (state RUN).
REQ-015 oFrameDone  out  1  SHALL pulse for one cycle when pixel (255,255) is committed.

Function
REQ-016 Storage SHALL be 65536 words x 9 bits {r,g,b}, address = {write_y, write_x}.
REQ-017 FSM SHALL have states CLEAR and RUN; reset SHALL enter CLEAR with clear address 0.
REQ-018 In CLEAR the block SHALL write 9'h000 to one address per cycle, address incrementing 0..65535, ignoring write_en.
REQ-019 CLEAR SHALL transition to RUN on the cycle after address 65535 is written (65536 cycles in CLEAR); oReady SHALL rise on that RUN entry.
REQ-020 In RUN, write inputs SHALL be registered in cycle N and committed to memory at the end of cycle N+1 (write latency 2 edges).
REQ-021 A write_en pulse during CLEAR SHALL be dropped, not deferred.
REQ-022 oFrameDone SHALL assert in the cycle after a committed write to address 16'hFFFF and be low otherwise; back-to-back commits there SHALL give back-to-back pulses.
REQ-023 Read path: cycle N sample iRequest/iCurrent_X/Y; cycle N+1 hold window flag and address; cycle N+2 drive outputs (latency 2).
REQ-024 In-window SHALL mean IMG_X0 <= X < IMG_X0+256 and IMG_Y0 <= Y < IMG_Y0+256; address = {(Y-IMG_Y0)[7:0], (X-IMG_X0)[7:0]}.
REQ-025 In-window colour SHALL expand each 3-bit field c to 8 bits as {c, c, c[2:1]} (0->0x00, 7->0xFF, 4->0x92).
REQ-026 Out-of-window requested pixels SHALL output BG_RGB with oValid=1.
REQ-027 iRequest low SHALL give oR=oG=oB=0 and oValid=0 two cycles later.
REQ-028 Same-address read and commit in the same cycle SHALL return the old data (read-before-write).
REQ-029 Reads during CLEAR SHALL be served normally and return the cleared or not-yet-cleared content.
REQ-030 Coordinate subtraction SHALL use 11-bit unsigned compare before subtract; no wrap-around into the window.

Reset
REQ-031 While iRST_N=0: oR=oG=oB=0, oValid=0, oReady=0, oFrameDone=0, FSM=CLEAR, clear address=0, pipelines invalid.
REQ-032 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from address 0 after release; pending write-pipeline data SHALL be discarded.
REQ-033 Memory contents SHALL NOT be reset asynchronously; only the CLEAR sweep zeroes them.

Verification
REQ-034 Release reset, hold write_en=1 -> oReady=0 for exactly 65536 cycles, then 1; a read of (IMG_X0,IMG_Y0) returns 0x000000.
REQ-035 RUN, write (3,5) rgb=(7,4,0), then request X=275, Y=177 -> two cycles later oR=0xFF, oG=0x92, oB=0x00, oValid=1.
REQ-036 Request X=271, Y=172 and X=528, Y=172 -> BG_RGB, oValid=1; iRequest=0 -> oValid=0, colour 0.
REQ-037 Write (255,255) -> oFrameDone high for exactly one cycle, two cycles after write_en sample.
REQ-038 Read and commit to same address in same cycle -> old value returned; next read returns new value.
REQ-039 Assert iRST_N=0 at clear address 30000 -> outputs zero immediately; after release, CLEAR lasts a full 65536 cycles.
